obj_ram_fetch: RTL

OBJ_RAM_FETCH -- requirements
Module: obj_ram_fetch

---
 rtl/obj_fetch_pkg.sv | 15 +
 rtl/obj_ram_fetch.sv | 137 +++++++++++++
 2 files changed

// File: rtl/obj_fetch_pkg.sv
// Shared types and defaults for the object RAM fetcher.
package obj_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CAPT,
        OUT
    } fetch_state_e;

    localparam int          BYTES_PER_OBJ = 4;
    localparam logic [10:0] DEF_BASE_ADDR = 11'h020;
    localparam int          DEF_NUM_OBJ   = 24;

endpackage

// File: rtl/obj_ram_fetch.sv
// Single-port RAM arbiter plus object fetcher: the CPU always wins the port,
// the fetcher assembles 4-byte records from idle cycles and hands them out.
module obj_ram_fetch
    import obj_fetch_pkg::*;
#(
    parameter int                ADDR_W    = 11,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
    parameter int                NUM_OBJ   = DEF_NUM_OBJ
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_clken,
    output logic              ram_wren,
    output logic [7:0]        ram_data,
    input  logic [7:0]        ram_q,
    output logic              obj_valid,
    input  logic              obj_ready,
    output logic [4:0]        obj_index,
    output logic [31:0]       obj_data
);

    fetch_state_e      state_q, state_d;
    logic [4:0]        index_q, index_d;
    logic [1:0]        byte_q, byte_d;
    logic [31:0]       data_q, data_d;
    logic              cap_vld_q, cap_vld_d;
    logic [1:0]        cap_lane_q, cap_lane_d;
    logic              done_q, done_d;
    logic              ack_q, ack_d;
    logic              fetch_issue;
    logic              last_obj;
    logic [ADDR_W-1:0] fetch_addr;

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        byte_d      = byte_q;
        data_d      = data_q;
        cap_vld_d   = 1'b0;
        cap_lane_d  = byte_q;
        done_d      = 1'b0;
        ack_d       = cpu_req;
        fetch_issue = (state_q == READ) && !cpu_req;
        last_obj    = (index_q == 5'(NUM_OBJ - 1));
        fetch_addr  = BASE_ADDR + ADDR_W'(index_q * BYTES_PER_OBJ) + ADDR_W'(byte_q);

        // ram_q belongs to the fetch issued last cycle, whatever the CPU does now
        if (cap_vld_q) begin
            data_d[{cap_lane_q, 3'b000} +: 8] = ram_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    index_d = '0;
                    byte_d  = '0;
                end
            end
            READ: begin
                if (fetch_issue) begin
                    cap_vld_d = 1'b1;
                    byte_d    = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        state_d = CAPT;
                    end
                end
            end
            CAPT: begin
                state_d = OUT;
            end
            OUT: begin
                if (obj_ready) begin
                    byte_d = '0;
                    if (last_obj) begin
                        index_d = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        index_d = index_q + 5'd1;
                        state_d = READ;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            index_q    <= '0;
            byte_q     <= '0;
            data_q     <= '0;
            cap_vld_q  <= 1'b0;
            cap_lane_q <= '0;
            done_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            byte_q     <= byte_d;
            data_q     <= data_d;
            cap_vld_q  <= cap_vld_d;
            cap_lane_q <= cap_lane_d;
            done_q     <= done_d;
            ack_q      <= ack_d;
        end
    end

    // Port is held idle while reset is asserted, even against a CPU request
    assign ram_clken   = reset_n && (cpu_req || fetch_issue);
    assign ram_wren    = reset_n && cpu_req && cpu_we;
    assign ram_address = cpu_req ? cpu_addr : fetch_addr;
    assign ram_data    = cpu_din;

    assign cpu_ack   = ack_q;
    assign cpu_dout  = ack_q ? ram_q : 8'h00;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign obj_valid = (state_q == OUT);
    assign obj_index = index_q;
    assign obj_data  = data_q;

endmodule
